priv_access_arbiter: RTL and testbench

- Request front-end directly upstream of the shared data memory.
- Arbitrates the user and admin request channels into a single memory command stream and tags each command with its privilege.
- Blocks user accesses that fall inside the admin-protected address window, so the memory never acts on user traffic with admin authority.
- Routes each memory response back to the channel that issued it.

---
 rtl/priv_arb_pkg.sv | 20 ++
 rtl/prot_range_check.sv | 14 +
 rtl/priv_access_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_priv_access_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/priv_arb_pkg.sv
// Shared types and default protected window for the privileged access arbiter.
// Imported by the arbiter top and any privileged initiator front-end.
package priv_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    DENY
  } state_e;

  typedef enum logic {
    SRC_USER,
    SRC_ADMIN
  } src_e;

  localparam logic [7:0] PROT_BASE_DEF  = 8'hC0;
  localparam logic [7:0] PROT_LIMIT_DEF = 8'hFF;

endpackage

// File: rtl/prot_range_check.sv
// Inclusive address window compare: hit when base <= addr <= limit.
// Pure combinational, shared by privileged initiators.
module prot_range_check #(
  parameter int AW = 8
) (
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] limit,
  output logic          hit
);

  assign hit = (addr >= base) && (addr <= limit);

endmodule

// File: rtl/priv_access_arbiter.sv
// User/admin request arbiter in front of the shared data memory.
// Define PRIV_AUDIT_EN to add the viol_count / viol_addr audit outputs.
module priv_access_arbiter
  import priv_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] PROT_BASE  = ADDR_WIDTH'(PROT_BASE_DEF),
  parameter logic [ADDR_WIDTH-1:0] PROT_LIMIT = ADDR_WIDTH'(PROT_LIMIT_DEF),
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  usr_valid,
  output logic                  usr_ready,
  input  logic                  usr_we,
  input  logic [ADDR_WIDTH-1:0] usr_addr,
  input  logic [DATA_WIDTH-1:0] usr_wdata,
  output logic                  usr_rsp_valid,
  output logic [DATA_WIDTH-1:0] usr_rsp_data,
  output logic                  usr_rsp_err,
  input  logic                  adm_valid,
  output logic                  adm_ready,
  input  logic                  adm_we,
  input  logic [ADDR_WIDTH-1:0] adm_addr,
  input  logic [DATA_WIDTH-1:0] adm_wdata,
  output logic                  adm_rsp_valid,
  output logic [DATA_WIDTH-1:0] adm_rsp_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_is_admin,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data
`ifdef PRIV_AUDIT_EN
  ,
  output logic [15:0]           viol_count,
  output logic [ADDR_WIDTH-1:0] viol_addr
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  state_e                  state_q;
  src_e                    src_q;
  logic [SW-1:0]           starve_q;
  logic                    mem_req_valid_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic                    mem_is_admin_q;
  logic                    usr_rsp_valid_q;
  logic                    usr_rsp_err_q;
  logic [DATA_WIDTH-1:0]   usr_rsp_data_q;
  logic                    adm_rsp_valid_q;
  logic [DATA_WIDTH-1:0]   adm_rsp_data_q;

  logic idle;
  logic usr_go;
  logic adm_go;
  logic usr_hit;

  prot_range_check #(
    .AW(ADDR_WIDTH)
  ) u_prot (
    .addr (usr_addr),
    .base (PROT_BASE),
    .limit(PROT_LIMIT),
    .hit  (usr_hit)
  );

  // Ready is gated by reset so nothing handshakes while reset is held.
  assign idle   = (state_q == IDLE) && reset_n;
  assign usr_go = idle && usr_valid &&
                  (!adm_valid || (starve_q == SMAX));
  assign adm_go = idle && adm_valid && !usr_go;

  assign usr_ready     = usr_go;
  assign adm_ready     = adm_go;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_is_admin  = mem_is_admin_q;
  assign usr_rsp_valid = usr_rsp_valid_q;
  assign usr_rsp_err   = usr_rsp_err_q;
  assign usr_rsp_data  = usr_rsp_data_q;
  assign adm_rsp_valid = adm_rsp_valid_q;
  assign adm_rsp_data  = adm_rsp_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      src_q           <= SRC_USER;
      starve_q        <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_is_admin_q  <= 1'b0;
      usr_rsp_valid_q <= 1'b0;
      usr_rsp_err_q   <= 1'b0;
      usr_rsp_data_q  <= '0;
      adm_rsp_valid_q <= 1'b0;
      adm_rsp_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (adm_go) begin
            mem_req_valid_q <= 1'b1;
            mem_we_q        <= adm_we;
            mem_addr_q      <= adm_addr;
            mem_wdata_q     <= adm_wdata;
            mem_is_admin_q  <= 1'b1;
            src_q           <= SRC_ADMIN;
            state_q         <= ISSUE;
            if (usr_valid && (starve_q != SMAX))
              starve_q <= starve_q + SW'(1);
          end else if (usr_go) begin
            starve_q <= '0;
            src_q    <= SRC_USER;
            if (usr_hit) begin
              usr_rsp_valid_q <= 1'b1;
              usr_rsp_err_q   <= 1'b1;
              usr_rsp_data_q  <= '0;
              state_q         <= DENY;
            end else begin
              mem_req_valid_q <= 1'b1;
              mem_we_q        <= usr_we;
              mem_addr_q      <= usr_addr;
              mem_wdata_q     <= usr_wdata;
              mem_is_admin_q  <= 1'b0;
              state_q         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // Stay here through the pulse cycle so no grant overlaps it.
          if (usr_rsp_valid_q || adm_rsp_valid_q) begin
            usr_rsp_valid_q <= 1'b0;
            usr_rsp_data_q  <= '0;
            adm_rsp_valid_q <= 1'b0;
            adm_rsp_data_q  <= '0;
            state_q         <= IDLE;
          end else if (mem_rsp_valid) begin
            if (src_q == SRC_ADMIN) begin
              adm_rsp_valid_q <= 1'b1;
              adm_rsp_data_q  <= mem_we_q ? '0 : mem_rsp_data;
            end else begin
              usr_rsp_valid_q <= 1'b1;
              usr_rsp_data_q  <= mem_we_q ? '0 : mem_rsp_data;
            end
          end
        end
        DENY: begin
          usr_rsp_valid_q <= 1'b0;
          usr_rsp_err_q   <= 1'b0;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PRIV_AUDIT_EN
  logic [15:0]           viol_count_q;
  logic [ADDR_WIDTH-1:0] viol_addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      viol_count_q <= '0;
      viol_addr_q  <= '0;
    end else if (usr_go && usr_hit) begin
      if (viol_count_q != 16'hFFFF)
        viol_count_q <= viol_count_q + 16'd1;
      viol_addr_q <= usr_addr;
    end
  end

  assign viol_count = viol_count_q;
  assign viol_addr  = viol_addr_q;
`endif

endmodule

// File: tb/tb_priv_access_arbiter.sv
// Directed bench for priv_access_arbiter with a one-deep memory model.
// Build with PRIV_AUDIT_EN to also exercise the audit outputs.
module tb_priv_access_arbiter;

  logic        clk;
  logic        reset_n;
  logic        usr_valid, usr_ready, usr_we;
  logic [7:0]  usr_addr;
  logic [31:0] usr_wdata;
  logic        usr_rsp_valid, usr_rsp_err;
  logic [31:0] usr_rsp_data;
  logic        adm_valid, adm_ready, adm_we;
  logic [7:0]  adm_addr;
  logic [31:0] adm_wdata;
  logic        adm_rsp_valid;
  logic [31:0] adm_rsp_data;
  logic        mem_req_valid, mem_we, mem_is_admin;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rdy, mem_drop, inj_rsp;
  logic        model_rsp, pend;
  logic [31:0] model_rdata, pend_data;
`ifdef PRIV_AUDIT_EN
  logic [15:0] viol_count;
  logic [7:0]  viol_addr;
`endif

  logic [31:0] mem [0:255];
  int          n_issue;
  logic        last_adm;
  logic [7:0]  last_addr;
  logic        gq[$];

  int n_tests = 0;
  int n_fail  = 0;

  priv_access_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .usr_valid    (usr_valid),
    .usr_ready    (usr_ready),
    .usr_we       (usr_we),
    .usr_addr     (usr_addr),
    .usr_wdata    (usr_wdata),
    .usr_rsp_valid(usr_rsp_valid),
    .usr_rsp_data (usr_rsp_data),
    .usr_rsp_err  (usr_rsp_err),
    .adm_valid    (adm_valid),
    .adm_ready    (adm_ready),
    .adm_we       (adm_we),
    .adm_addr     (adm_addr),
    .adm_wdata    (adm_wdata),
    .adm_rsp_valid(adm_rsp_valid),
    .adm_rsp_data (adm_rsp_data),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_rdy),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_is_admin (mem_is_admin),
    .mem_rsp_valid(model_rsp | inj_rsp),
    .mem_rsp_data (model_rdata)
`ifdef PRIV_AUDIT_EN
    ,
    .viol_count   (viol_count),
    .viol_addr    (viol_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: accept, then answer two edges later; write acks carry junk data.
  initial begin
    n_issue = 0;
    pend    = 1'b0;
    model_rsp = 1'b0;
    model_rdata = '0;
  end

  always @(posedge clk) begin
    model_rsp   <= pend;
    model_rdata <= pend_data;
    pend        <= 1'b0;
    if (reset_n && mem_req_valid && mem_rdy) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      pend      <= !mem_drop;
      pend_data <= mem_we ? 32'hBAD0_BAD0 : mem[mem_addr];
      n_issue   <= n_issue + 1;
      last_adm  <= mem_is_admin;
      last_addr <= mem_addr;
    end
  end

  always @(posedge clk) begin
    if (reset_n && usr_valid && usr_ready) gq.push_back(1'b0);
    if (reset_n && adm_valid && adm_ready) gq.push_back(1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns response data/err, whether a memory
  // command was up the cycle after the handshake, and response latency.
  task automatic txn(input bit adm, input bit we, input logic [7:0] a,
                     input logic [31:0] d, output logic [31:0] rd,
                     output logic err, output logic req1, output int lat);
    int n;
    if (adm) begin
      adm_valid = 1'b1; adm_we = we; adm_addr = a; adm_wdata = d;
    end else begin
      usr_valid = 1'b1; usr_we = we; usr_addr = a; usr_wdata = d;
    end
    #1;
    n = 0;
    while (!(adm ? adm_ready : usr_ready) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("grant_timeout", 32'(n < 30), 32'd1);
    @(negedge clk);
    adm_valid = 1'b0;
    usr_valid = 1'b0;
    req1 = mem_req_valid;
    n = 0;
    while (!(adm ? adm_rsp_valid : usr_rsp_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", 32'(n < 40), 32'd1);
    lat = n;
    rd  = adm ? adm_rsp_data : usr_rsp_data;
    err = adm ? 1'b0 : usr_rsp_err;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        err, req1;
  int          lat, n0, bad, n;

  initial begin
    reset_n = 1'b0;
    usr_valid = 1'b1; usr_we = 1'b0; usr_addr = '0; usr_wdata = '0;
    adm_valid = 1'b0; adm_we = 1'b0; adm_addr = '0; adm_wdata = '0;
    mem_rdy = 1'b1; mem_drop = 1'b0; inj_rsp = 1'b0;
    #12;
    chk("rst_usr_ready", usr_ready, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_usr_rsp_valid", usr_rsp_valid, 0);
    chk("rst_usr_rsp_err", usr_rsp_err, 0);
    chk("rst_adm_rsp_valid", adm_rsp_valid, 0);
    usr_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    txn(1, 1, 8'h10, 32'h0000_00AA, rd, err, req1, lat);
    chk("adm_wr_data_zero", rd, 0);
    txn(1, 1, 8'hC0, 32'h0000_1234, rd, err, req1, lat);
    txn(1, 1, 8'h40, 32'h0000_4444, rd, err, req1, lat);

    txn(0, 0, 8'h10, 32'h0, rd, err, req1, lat);
    chk("usr_rd_req_latency", req1, 1);
    chk("usr_rd_data", rd, 32'hAA);
    chk("usr_rd_err", err, 0);
    chk("usr_rd_is_admin", last_adm, 0);
    chk("usr_rd_addr", last_addr, 8'h10);

    n0 = n_issue;
    txn(0, 1, 8'hC0, 32'hDEAD, rd, err, req1, lat);
    chk("deny_c0_err", err, 1);
    chk("deny_c0_data", rd, 0);
    chk("deny_c0_latency", lat, 0);
    chk("deny_c0_no_req", req1, 0);
    chk("deny_c0_no_issue", n_issue, n0);
    txn(1, 0, 8'hC0, 32'h0, rd, err, req1, lat);
    chk("adm_rd_c0", rd, 32'h1234);
    chk("adm_rd_is_admin", last_adm, 1);

    n0 = n_issue;
    txn(0, 1, 8'hBF, 32'h55, rd, err, req1, lat);
    chk("usr_wr_bf_err", err, 0);
    chk("usr_wr_bf_data", rd, 0);
    chk("usr_wr_bf_issued", n_issue, n0 + 1);
    chk("usr_wr_bf_mem", mem[8'hBF], 32'h55);
    txn(0, 1, 8'hFF, 32'h66, rd, err, req1, lat);
    chk("deny_ff_err", err, 1);
    chk("deny_ff_no_issue", n_issue, n0 + 1);

    gq.delete();
    usr_valid = 1'b1; usr_we = 1'b0; usr_addr = 8'h20;
    adm_valid = 1'b1; adm_we = 1'b0; adm_addr = 8'h50;
    n = 0;
    while (gq.size() < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    usr_valid = 1'b0;
    adm_valid = 1'b0;
    chk("starve_timeout", 32'(n < 500), 1);
    for (int i = 0; i < 10; i++) begin
      logic g;
      g = (i < gq.size()) ? gq[i] : 1'bx;
      chk($sformatf("grant_seq%0d", i), g, (i % 5 == 4) ? 0 : 1);
    end
    repeat (10) @(negedge clk);

    mem_rdy = 1'b0;
    usr_valid = 1'b1; usr_we = 1'b0; usr_addr = 8'h40;
    adm_valid = 1'b1; adm_we = 1'b1; adm_addr = 8'h30; adm_wdata = 32'h77;
    #1;
    chk("stall_adm_ready", adm_ready, 1);
    chk("stall_usr_ready", usr_ready, 0);
    @(negedge clk);
    adm_valid = 1'b0;
    bad = 0;
    repeat (5) begin
      if (!mem_req_valid || mem_addr !== 8'h30 || mem_wdata !== 32'h77 ||
          !mem_we || !mem_is_admin || usr_ready || adm_ready)
        bad++;
      @(negedge clk);
    end
    chk("stall_stable", bad, 0);
    mem_rdy = 1'b1;
    n = 0;
    while (!adm_rsp_valid && n < 20) begin
      if (usr_ready) bad++;
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_timeout", 32'(n < 20), 1);
    chk("stall_no_grant", bad, 0);
    chk("no_grant_in_pulse", usr_ready, 0);
    usr_valid = 1'b0;
    @(negedge clk);
    txn(0, 0, 8'h40, 32'h0, rd, err, req1, lat);
    chk("post_stall_usr_rd", rd, 32'h4444);
    chk("stall_wr_mem", mem[8'h30], 32'h77);

    mem_drop = 1'b1;
    adm_valid = 1'b1; adm_we = 1'b0; adm_addr = 8'h10;
    #1;
    chk("rstmid_grant", adm_ready, 1);
    @(negedge clk);
    adm_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_in_wait", mem_req_valid, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_mem_addr", mem_addr, 0);
    chk("rstmid_is_admin", mem_is_admin, 0);
    chk("rstmid_adm_rsp", adm_rsp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    mem_drop = 1'b0;
    inj_rsp = 1'b1;
    @(negedge clk);
    inj_rsp = 1'b0;
    bad = 0;
    repeat (4) begin
      if (usr_rsp_valid || adm_rsp_valid) bad++;
      @(negedge clk);
    end
    chk("rstmid_no_pulse", bad, 0);
    txn(0, 0, 8'h10, 32'h0, rd, err, req1, lat);
    chk("post_rst_usr_rd", rd, 32'hAA);

`ifdef PRIV_AUDIT_EN
    chk("audit_cnt_after_rst", viol_count, 0);
    txn(0, 1, 8'hC5, 32'h1, rd, err, req1, lat);
    txn(0, 1, 8'hE0, 32'h2, rd, err, req1, lat);
    txn(0, 1, 8'hD3, 32'h3, rd, err, req1, lat);
    chk("audit_count", viol_count, 3);
    chk("audit_addr", viol_addr, 8'hD3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
